// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes, FSM state and matrix storage types for the matrix multiply sequencer.
package matmul_pkg;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t;
  typedef logic [W-1:0] elem_t;
  typedef elem_t mat_t [N][N];
endpackage

// File: rtl/matmul_index_ctr.sv
// matmul_index_ctr: row-major (i,j) walk over an NxN result, flagging the final element.
module matmul_index_ctr
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic          o_last
);
  logic [IW-1:0] r_i, r_j;
  // N is a power of two, so both indices wrap back to 0 naturally after the last element
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_en) begin
      r_j <= r_j + IW'(1);
      if (r_j == IW'(N - 1)) r_i <= r_i + IW'(1);
    end
  end
  assign o_i    = r_i;
  assign o_j    = r_j;
  assign o_last = (r_i == IW'(N - 1)) && (r_j == IW'(N - 1));
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: holds A, B, C and time-shares an external DotProd to compute C = A x B,
// one C element per clock.
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [IW-1:0]         load_row,
  input  logic [IW-1:0]         load_col,
  input  logic [W-1:0]          load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [IW-1:0]         rd_row,
  input  logic [IW-1:0]         rd_col,
  output logic [W-1:0]          rd_data,
  output logic [N-1:0][W-1:0]   dp_in1,
  output logic [N-1:0][W-1:0]   dp_in2,
  input  logic [W-1:0]          dp_result
);
  mm_state_t     r_state, w_next;
  mat_t          r_a, r_b, r_c;
  logic [IW-1:0] w_i, w_j;
  logic          w_last, w_idle, w_run;

  assign w_idle = (r_state == IDLE);
  assign w_run  = (r_state == RUN);
  assign busy   = w_run;
  assign done   = (r_state == DONE);

  matmul_index_ctr u_idx (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_run),
    .i_en   (w_run),
    .o_i    (w_i),
    .o_j    (w_j),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_next = w_idle ? (start ? RUN : IDLE) :
             w_run  ? (w_last ? DONE : RUN) : IDLE;
  end

  // a load issued together with start lands at the same edge, so RUN sees the new value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
          r_c[r][c] <= '0;
        end
    end else begin
      if (w_idle && load_en && !load_sel) r_a[load_row][load_col] <= load_data;
      if (w_idle && load_en && load_sel) r_b[load_row][load_col] <= load_data;
      if (w_run) r_c[w_i][w_j] <= dp_result;
    end
  end

  always_comb begin
    dp_in1 = '0;
    dp_in2 = '0;
    for (int k = 0; k < N; k++) begin
      dp_in1[k] = w_run ? r_a[w_i][k] : '0;
      dp_in2[k] = w_run ? r_b[k][w_j] : '0;
    end
  end

  assign rd_data = r_c[rd_row][rd_col];
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized and directed checks of matmul_sequencer against a plain matrix model.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  logic                clk = 0;
  logic                reset, load_en, load_sel, start, busy, done;
  logic [IW-1:0]       load_row, load_col, rd_row, rd_col;
  logic [W-1:0]        load_data, rd_data, dp_result;
  logic [N-1:0][W-1:0] dp_in1, dp_in2;

  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];
  logic [W-1:0] mc [N][N];
  int tests = 0, fails = 0;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .load_row(load_row), .load_col(load_col), .load_data(load_data),
    .start(start), .busy(busy), .done(done), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    dp_result = '0;
    for (int k = 0; k < N; k++) dp_result = dp_result + dp_in1[k] * dp_in2[k];
  end

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 0; mb[r][c] = 0; mc[r][c] = 0;
      end
  endtask

  task automatic compute_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        logic [W-1:0] s;
        s = 0;
        for (int k = 0; k < N; k++) s = s + ma[r][k] * mb[k][c];
        mc[r][c] = s;
      end
  endtask

  task automatic load_all();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          load_en = 1; load_sel = s[0]; load_row = IW'(r); load_col = IW'(c);
          load_data = s == 0 ? ma[r][c] : mb[r][c];
        end
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic read_c(input int r, input int c, output logic [W-1:0] v);
    @(negedge clk);
    rd_row = IW'(r); rd_col = IW'(c);
    #1 v = rd_data;
  endtask

  // Issues start, then watches a fixed 40-cycle window; optionally loads A[0][0]=5 with start,
  // and at window cycle inject_at attempts a load of 99 plus a second start.
  task automatic run_mult(input int inject_at, input bit ld5, output int nbusy, output int ndone,
                          output logic [N-1:0][W-1:0] d1, output logic [N-1:0][W-1:0] d2,
                          output logic [N-1:0][W-1:0] e1, output logic [N-1:0][W-1:0] e2);
    @(negedge clk);
    start = 1;
    if (ld5) begin
      load_en = 1; load_sel = 0; load_row = 0; load_col = 0; load_data = 5;
    end
    nbusy = 0; ndone = 0; d1 = '0; d2 = '0; e1 = '0; e2 = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
      if (n == 0) begin d1 = dp_in1; d2 = dp_in2; end
      if (n == 39) begin e1 = dp_in1; e2 = dp_in2; end
      start = (n == inject_at);
      load_en = (n == inject_at); load_sel = 0; load_row = 0; load_col = 0; load_data = 99;
    end
    start = 0; load_en = 0;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset = 1; load_en = 0; load_sel = 0; start = 0; load_row = 0; load_col = 0;
    load_data = 0; rd_row = 0; rd_col = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    clear_model();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    tests++;
    if (dp_in1 !== '0 || dp_in2 !== '0) begin
      fails++; $display("FAIL reset_dp dp_in1=%h dp_in2=%h expected 0", dp_in1, dp_in2);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, v);
        tests++;
        if (v !== '0) begin
          fails++; $display("FAIL reset_c C[%0d][%0d] got %0h expected 0", r, c, v);
        end
      end
  endtask

  task automatic test_identity();
    int nb, nd;
    logic [N-1:0][W-1:0] d1, d2, e1, e2;
    logic [W-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 4 * r + c;
      end
    compute_model();
    load_all();
    run_mult(-1, 0, nb, nd, d1, d2, e1, e2);
    tests++;
    if (nb != N * N) begin fails++; $display("FAIL identity_busy got %0d cycles expected %0d", nb, N * N); end
    tests++;
    if (nd != 1) begin fails++; $display("FAIL identity_done got %0d pulses expected 1", nd); end
    for (int k = 0; k < N; k++) begin
      tests++;
      if (d1[k] !== ma[0][k] || d2[k] !== mb[k][0]) begin
        fails++; $display("FAIL identity_dp k=%0d got %0h/%0h expected %0h/%0h", k, d1[k], d2[k], ma[0][k], mb[k][0]);
      end
    end
    tests++;
    if (e1 !== '0 || e2 !== '0) begin fails++; $display("FAIL identity_dp_idle got %h/%h expected 0", e1, e2); end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, v);
        tests++;
        if (v !== mb[r][c]) begin
          fails++; $display("FAIL identity_c C[%0d][%0d] got %0h expected %0h", r, c, v, mb[r][c]);
        end
      end
  endtask

  task automatic test_rowscale();
    int nb, nd;
    logic [N-1:0][W-1:0] d1, d2, e1, e2;
    logic [W-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = r + 1;
        mb[r][c] = 2;
      end
    compute_model();
    load_all();
    run_mult(-1, 0, nb, nd, d1, d2, e1, e2);
    tests++;
    if (nb != N * N || nd != 1) begin fails++; $display("FAIL rowscale_timing busy=%0d done=%0d expected 16 1", nb, nd); end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, v);
        tests++;
        if (v !== 8 * (r + 1)) begin
          fails++; $display("FAIL rowscale_c C[%0d][%0d] got %0h expected %0h", r, c, v, 8 * (r + 1));
        end
      end
  endtask

  task automatic test_run_ignore();
    int nb, nd;
    logic [N-1:0][W-1:0] d1, d2, e1, e2;
    logic [W-1:0] v;
    for (int pass = 0; pass < 2; pass++) begin
      run_mult(pass == 0 ? 3 : -1, 0, nb, nd, d1, d2, e1, e2);
      tests++;
      if (nb != N * N || nd != 1) begin
        fails++; $display("FAIL ignore_timing pass%0d busy=%0d done=%0d expected 16 1", pass, nb, nd);
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          read_c(r, c, v);
          tests++;
          if (v !== mc[r][c]) begin
            fails++; $display("FAIL ignore_c pass%0d C[%0d][%0d] got %0h expected %0h", pass, r, c, v, mc[r][c]);
          end
        end
    end
  endtask

  task automatic test_start_with_load();
    int nb, nd;
    logic [N-1:0][W-1:0] d1, d2, e1, e2;
    logic [W-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 4 * r + c;
      end
    load_all();
    ma[0][0] = 5;
    compute_model();
    run_mult(-1, 1, nb, nd, d1, d2, e1, e2);
    tests++;
    if (nb != N * N || nd != 1) begin fails++; $display("FAIL startload_timing busy=%0d done=%0d expected 16 1", nb, nd); end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, v);
        tests++;
        if (v !== mc[r][c]) begin
          fails++; $display("FAIL startload_c C[%0d][%0d] got %0h expected %0h", r, c, v, mc[r][c]);
        end
      end
  endtask

  task automatic test_random(input int iters);
    int nb, nd;
    logic [N-1:0][W-1:0] d1, d2, e1, e2;
    logic [W-1:0] v;
    for (int it = 0; it < iters; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = $urandom;
          mb[r][c] = (it == 0) ? $urandom_range(0, 255) : $urandom;
        end
      compute_model();
      load_all();
      run_mult(-1, 0, nb, nd, d1, d2, e1, e2);
      tests++;
      if (nb != N * N || nd != 1) begin fails++; $display("FAIL random_timing it%0d busy=%0d done=%0d expected 16 1", it, nb, nd); end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          read_c(r, c, v);
          tests++;
          if (v !== mc[r][c]) begin
            fails++; $display("FAIL random_c it%0d C[%0d][%0d] got %0h expected %0h", it, r, c, v, mc[r][c]);
          end
        end
    end
  endtask

  task automatic test_reset_midrun();
    int nd;
    logic [W-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = $urandom_range(1, 1000);
        mb[r][c] = $urandom_range(1, 1000);
      end
    load_all();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    clear_model();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midreset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    nd = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    tests++;
    if (nd != 0) begin fails++; $display("FAIL midreset_done got %0d pulses expected 0", nd); end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, v);
        tests++;
        if (v !== '0) begin
          fails++; $display("FAIL midreset_c C[%0d][%0d] got %0h expected 0", r, c, v);
        end
      end
    test_random(1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rowscale();
    test_run_ignore();
    test_start_with_load();
    test_random(2);
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
